// File: rtl/led_blink_sched.sv
// led_blink_sched: round-robin owner of the single board LED.
// Requesters ask for a blink burst at their own rate; the owner gets
// HOLD_TOGGLES toggles at half-period PRESCALE<<rate, then the LED is
// released and re-arbitrated starting after the last owner.
// Optional build macro LED_IDLE_HEARTBEAT_EN: dim 1/8-duty glow while idle.
module led_blink_sched #(
    parameter int NREQ         = 4,
    parameter int PRESCALE     = 500,
    parameter int HOLD_TOGGLES = 4,
    parameter int CW           = 26
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [2*NREQ-1:0]   rate,
    output logic [NREQ-1:0]     grant,
    output logic [NREQ-1:0]     done,
    output logic                busy,
    output logic                LED
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(HOLD_TOGGLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BLINK   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cont;
    logic [TW-1:0]   tcnt;
    logic [1:0]      rlat;
    logic [IW-1:0]   last;
    logic [IW-1:0]   owner;
    logic [1:0]      rate_arr [NREQ];
    logic [IW-1:0]   sel;
    logic [CW-1:0]   term;
    logic            idle_led;

    // Split the packed rate bus into one 2-bit code per requester
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rate
        assign rate_arr[gi] = rate[2*gi +: 2];
    end

    // Last prescaler count of a half-period, using the full CW-bit shift
    assign term = (CW'(PRESCALE) << rlat) - CW'(1);

    // Round-robin pick: scan from last+1 upward with wrap; the nearest
    // set bit wins because it is written last
    always_comb begin
        int idx;
        idx = 0;
        sel = last;
        for (int k = NREQ; k >= 1; k--) begin
            idx = int'(last) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req[idx]) begin
                sel = idx[IW-1:0];
            end
        end
    end

`ifdef LED_IDLE_HEARTBEAT_EN
    logic [7:0] hb;

    // Free-running glow phase counter, runs in every state
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            hb <= 8'd0;
        end else begin
            hb <= hb + 8'd1;
        end
    end

    assign idle_led = (hb[7:5] == 3'b000);
`else
    assign idle_led = 1'b0;
`endif

    // Arbitration / burst FSM with registered outputs
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            grant <= '0;
            done  <= '0;
            busy  <= 1'b0;
            LED   <= 1'b0;
            cont  <= '0;
            tcnt  <= '0;
            rlat  <= 2'b00;
            last  <= IW'(NREQ - 1);
            owner <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner <= sel;
                        grant <= NREQ'(1) << sel;
                        busy  <= 1'b1;
                        rlat  <= rate_arr[sel];
                        cont  <= '0;
                        tcnt  <= '0;
                        LED   <= 1'b0;
                        state <= BLINK;
                    end else begin
                        LED <= idle_led;
                    end
                end
                BLINK: begin
                    if (!req[owner]) begin
                        // Abandon beats a coincident final toggle: no done
                        grant <= '0;
                        busy  <= 1'b0;
                        LED   <= 1'b0;
                        state <= RELEASE;
                    end else if (cont == term) begin
                        cont <= '0;
                        tcnt <= tcnt + TW'(1);
                        if (tcnt == TW'(HOLD_TOGGLES - 1)) begin
                            // Even toggle count: this final toggle lands on 0
                            done  <= grant;
                            grant <= '0;
                            busy  <= 1'b0;
                            LED   <= 1'b0;
                            state <= RELEASE;
                        end else begin
                            LED <= ~LED;
                        end
                    end else begin
                        cont <= cont + CW'(1);
                    end
                end
                RELEASE: begin
                    last  <= owner;
                    LED   <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_blink_sched.sv
// Bench for led_blink_sched: a burst-level model (elapsed cycles since
// grant, divided by the half-period) predicts every output each cycle,
// plus literal expectations for reset, single burst, round robin,
// abandon, rate latching and asynchronous reset.
module tb_led_blink_sched;
    localparam int NREQ     = 4;
    localparam int PRESCALE = 4;
    localparam int HOLD     = 4;
    localparam int CW       = 26;

    logic            clk   = 1'b0;
    logic            reset = 1'b0;
    logic [3:0]      req   = 4'b0000;
    logic [7:0]      rate  = 8'h00;
    logic [3:0]      grant;
    logic [3:0]      done;
    logic            busy;
    logic            led;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    led_blink_sched #(
        .NREQ(NREQ), .PRESCALE(PRESCALE), .HOLD_TOGGLES(HOLD), .CW(CW)
    ) dut (
        .CLOCK_50(clk), .reset(reset), .req(req), .rate(rate),
        .grant(grant), .done(done), .busy(busy), .LED(led)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_phase;   // 0 idle, 1 burst, 2 release
    int         m_owner;
    int         m_last;
    int         m_T;
    int         m_el;
    int         m_hb;
    logic [3:0] e_grant;
    logic [3:0] e_done;
    logic       e_busy;
    logic       e_led;

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_last = NREQ - 1; m_T = PRESCALE;
        m_el = 0; m_hb = 0;
        e_grant = 4'b0; e_done = 4'b0; e_busy = 1'b0; e_led = 1'b0;
    endtask

    task automatic end_burst(input bit normal);
        m_phase = 2;
        e_grant = 4'b0;
        e_busy  = 1'b0;
        e_led   = 1'b0;
        if (normal) e_done = 4'(1 << m_owner);
    endtask

    task automatic model_step();
        int hb_now;
        hb_now = m_hb;
        m_hb = (m_hb + 1) % 256;
        e_done = 4'b0;
        if (m_phase == 0) begin
            if (req != 4'b0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (req[(m_last + k) % NREQ]) begin
                        m_owner = (m_last + k) % NREQ;
                        break;
                    end
                end
                m_T = PRESCALE << rate[2*m_owner +: 2];
                m_el = 0;
                m_phase = 1;
                e_grant = 4'(1 << m_owner);
                e_busy = 1'b1;
                e_led = 1'b0;
            end else begin
`ifdef LED_IDLE_HEARTBEAT_EN
                e_led = (hb_now < 32);
`else
                e_led = 1'b0;
`endif
            end
        end else if (m_phase == 1) begin
            m_el++;
            if (!req[m_owner]) begin
                end_burst(1'b0);
            end else if (m_el % m_T == 0) begin
                if (m_el == HOLD * m_T) end_burst(1'b1);
                else e_led = ((m_el / m_T) % 2) == 1;
            end
        end else begin
            m_last = m_owner;
            m_phase = 0;
            e_led = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [3:0] prev_grant;
        prev_grant = 4'b0;
        forever begin
            @(posedge clk);
            #1;
            check("grant", 32'(grant), 32'(e_grant));
            check("done",  32'(done),  32'(e_done));
            check("busy",  32'(busy),  32'(e_busy));
            check("led",   32'(led),   32'(e_led));
            if (done != 4'b0) done_cnt++;
            if (grant != 4'b0 && grant != prev_grant)
                $display("burst grant=%b rate=%b t=%0t", grant, rate, $time);
            prev_grant = grant;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_grant();
        int n;
        n = 0;
        while (grant == 4'b0 && n < 50) begin
            tick(1);
            n++;
        end
        check("wait_grant", 32'(grant != 4'b0), 32'd1);
    endtask

    task automatic measure_burst(output int len, output int tog);
        logic pl;
        pl = led; len = 0; tog = 0;
        while (grant != 4'b0 && len < 1000) begin
            len++;
            tick(1);
            if (grant != 4'b0 && led != pl) tog++;
            pl = led;
        end
    endtask

    task automatic measure_gap(output int gap);
        gap = 0;
        while (grant == 4'b0 && gap < 50) begin
            gap++;
            tick(1);
        end
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int len, tog, gap, dc0;
        logic [3:0] rr_exp [4];
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010;
        rr_exp[2] = 4'b1000; rr_exp[3] = 4'b0001;

        // Reset held with all requesting
        reset = 1'b0; req = 4'b1111; rate = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("rst_grant", 32'(grant), 32'd0);
            check("rst_busy",  32'(busy),  32'd0);
            check("rst_led",   32'(led),   32'd0);
            check("rst_done",  32'(done),  32'd0);
        end
        reset = 1'b1;
        tick(1);
        check("first_grant", 32'(grant), 32'b0001);
        req = 4'b0000;
        tick(3);

        // Single burst, rate 1 -> half-period 8
        req = 4'b0100; rate = 8'b00_01_00_00;
        wait_grant();
        check("single_grant", 32'(grant), 32'b0100);
        measure_burst(len, tog);
        check("single_len", 32'(len), 32'd32);
        check("single_toggles", 32'(tog), 32'd3);
        check("single_done", 32'(done), 32'b0100);
        req = 4'b0000;
        tick(1);
        check("single_done_once", 32'(done), 32'd0);
        tick(2);

        // Round robin from a fresh reset, req held
        reset = 1'b0; req = 4'b1011; rate = 8'h00;
        tick(2);
        reset = 1'b1;
        for (int b = 0; b < 4; b++) begin
            wait_grant();
            check("rr_order", 32'(grant), 32'(rr_exp[b]));
            measure_burst(len, tog);
            check("rr_len", 32'(len), 32'd16);
            if (b < 3) begin
                measure_gap(gap);
                check("rr_gap_ge2", 32'(gap >= 2), 32'd1);
            end
        end
        req = 4'b0000;
        tick(3);

        // Abandon after the 2nd toggle
        dc0 = done_cnt;
        req = 4'b0001;
        wait_grant();
        tick(8);
        req = 4'b0000;
        tick(1);
        check("abn_grant", 32'(grant), 32'd0);
        check("abn_led", 32'(led), 32'd0);
        tick(2);
        check("abn_no_done", 32'(done_cnt - dc0), 32'd0);

        // Abandon coinciding with the final toggle
        req = 4'b0001;
        wait_grant();
        tick(15);
        req = 4'b0000;
        tick(1);
        check("abn4_grant", 32'(grant), 32'd0);
        tick(2);
        check("abn4_no_done", 32'(done_cnt - dc0), 32'd0);

        // Rate latched at grant: change 00 -> 11 mid-burst
        req = 4'b0001; rate = 8'h00;
        wait_grant();
        len = 0;
        while (grant != 4'b0 && len < 1000) begin
            len++;
            if (len == 3) rate = 8'b0000_0011;
            tick(1);
        end
        check("latch_len", 32'(len), 32'd16);
        req = 4'b0000; rate = 8'h00;
        tick(3);

        // Asynchronous reset between edges
        req = 4'b0010;
        wait_grant();
        tick(5);
        #1 reset = 1'b0;
        #1;
        check("async_grant", 32'(grant), 32'd0);
        check("async_busy",  32'(busy),  32'd0);
        check("async_led",   32'(led),   32'd0);
        tick(2);
        reset = 1'b1;
        tick(1);
        check("post_rst_grant", 32'(grant), 32'b0010);
        req = 4'b0000;
        tick(3);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) req = 4'($urandom);
            rate = 8'($urandom);
            if ($urandom_range(0, 599) == 0) begin
                #1 reset = 1'b0;
                tick(1);
                reset = 1'b1;
            end else begin
                tick(1);
            end
        end

        // Long idle stretch
        req = 4'b0000;
        tick(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_blink_sched.md
Name: led_blink_sched

Overview:
- Round-robin scheduler that shares the single board LED between NREQ requesters.
- Each requester asks for a blink burst at its own rate. The block grants the LED to one requester at a time and runs the prescaler/toggle datapath for a fixed number of toggles.
- After the burst it releases the LED and re-arbitrates.
- Sits between status sources (error, heartbeat, activity) and the LED pin on the CLOCK_50 domain.

Parameters:
- NREQ, 4, number of requesters (2..8).
- PRESCALE, 500, base half-period in CLOCK_50 cycles (>=2).
- HOLD_TOGGLES, 4, LED toggles per burst; must be even (>=2) so a burst ends with LED=0.
- CW, 26, prescaler counter width; PRESCALE<<3 must fit in CW bits.

Ports:
- CLOCK_50  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req  in  NREQ  level request per requester; held high until done or abandon.
- rate  in  2*NREQ  per-requester rate code r[1:0] at bits [2i+1:2i]; half-period = PRESCALE<<r.
- grant  out  NREQ  one-hot owner of the LED; 0 when idle.
- done  out  NREQ  one-cycle pulse on the owner's bit when its burst completes normally.
- busy  out  1  high whenever grant != 0.
- LED  out  1  LED drive, registered.

Behaviour:
- Reset (reset=0, asynchronous):
  - grant=0, done=0, busy=0, LED=0.
  - Prescaler cont=0, toggle count tcnt=0, state=IDLE.
  - Round-robin pointer last=NREQ-1, so requester 0 has first priority.
- States: IDLE, BLINK, RELEASE.
- IDLE:
  - Sample req on each edge.
  - If any bit is set, select the first set bit scanning last+1, last+2, ... with wrap modulo NREQ.
  - Next edge actions: grant=onehot(sel), busy=1, latch rate code of sel into rlat, cont=0, tcnt=0, LED=0, state=BLINK.
  - Latency: req high before edge k -> grant high after edge k.
- BLINK:
  - cont increments every cycle.
  - When cont == (PRESCALE<<rlat)-1: cont=0, LED toggles, tcnt+1.
  - The toggle with tcnt reaching HOLD_TOGGLES sets state=RELEASE and leaves LED=0.
  - rate changes during BLINK are ignored (rlat held).
  - Other requesters' req changes are ignored until RELEASE.
- Abandon:
  - If the owner's req is 0 at any BLINK edge: next edge LED=0, state=RELEASE, no done pulse.
  - Abandon has priority over a simultaneous final toggle, so no done.
- RELEASE (exactly one cycle):
  - grant=0, busy=0, LED=0.
  - done pulses on the owner bit only for normal completion.
  - last=owner index, then state=IDLE.
- Consequences of the single RELEASE cycle:
  - Back-to-back requesters see at least 2 cycles with grant=0 between bursts (RELEASE plus IDLE sampling).
  - A requester still holding req after done is re-granted only after other pending requesters (round-robin fairness).
- Burst length: normal burst spans HOLD_TOGGLES*(PRESCALE<<r) cycles in BLINK.
- Reset mid-operation: everything returns to reset values immediately; no done pulse.
- Width rules:
  - cont is CW bits unsigned.
  - The terminal compare uses the full CW-bit shifted value.
  - tcnt is wide enough for HOLD_TOGGLES.

Optional Feature:
- Macro: LED_IDLE_HEARTBEAT_EN.
- When defined:
  - A free-running 8-bit counter runs in all states.
  - In IDLE only, LED = (hb[7:5]==0), i.e. 1/8 duty dim glow.
  - LED is forced 0 on the cycle leaving IDLE; BLINK/RELEASE behaviour is unchanged.
  - Counter resets to 0.
- When undefined: LED=0 in IDLE and no heartbeat counter exists.

Test Plan:
- Bench parameters: PRESCALE=4, HOLD_TOGGLES=4, NREQ=4.
- Reset: hold reset=0 for 3 cycles with req=4'b1111 -> grant=0, busy=0, LED=0, done=0 throughout. Release reset -> grant=4'b0001 one edge later.
- Single burst: req=4'b0100, rate[5:4]=2'b01 -> grant=4'b0100. LED toggles every 8 cycles (1,0,1,0). After 32 BLINK cycles grant=0 and done=4'b0100 for exactly one cycle.
- Round-robin: req=4'b1011 held constant -> grant order 0001, 0010, 1000, 0001. Each burst is 16 cycles at rate 0 and is followed by >=2 cycles of grant=0.
- Abandon: req=4'b0001, drop req[0] after the 2nd toggle -> next edge LED=0, one RELEASE cycle, then grant=0 with done never pulsed. Same check with req drop coinciding with the 4th toggle -> no done.
- Rate latch and async reset: change rate[1:0] from 00 to 11 mid-burst -> half-period stays 4. Assert reset=0 between clock edges mid-burst -> outputs clear immediately, not at the next edge.
- With LED_IDLE_HEARTBEAT_EN defined and req=0: LED high exactly 32 of every 256 cycles. A request arriving suppresses the glow from the grant edge onward.
